// File: rtl/uart_pkg.sv
// Shared types, widths and baud-timing helpers for the uart transmitter and receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int BIT_CNT_W  = 3;
  localparam int BAUD_CNT_W = 16;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int half_bit(input int clk_freq, input int baud);
    return clks_per_bit(clk_freq, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_if.sv
// Fabric-side byte handshake of the uart: write strobe/byte out, status and received byte back.
interface uart_if;

  logic       wr_en;
  logic [7:0] tx_byte;
  logic       tx_empty;
  logic       rx_full;
  logic [7:0] rx_byte;

  modport master (
    output wr_en,
    output tx_byte,
    input  tx_empty,
    input  rx_full,
    input  rx_byte
  );

  modport slave (
    input  wr_en,
    input  tx_byte,
    output tx_empty,
    output rx_full,
    output rx_byte
  );

endinterface

// File: rtl/uart_rx.sv
// 8N1 deserializer: synchronizes rx, validates the start bit at half period, samples bit centres.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic       rx_full_o,
  output logic [7:0] byte_o
);

  localparam logic [BAUD_CNT_W-1:0] BIT_LAST  = BAUD_CNT_W'(clks_per_bit(CLK_FREQ, BAUD) - 1);
  localparam logic [BAUD_CNT_W-1:0] HALF_LAST = BAUD_CNT_W'(half_bit(CLK_FREQ, BAUD) - 1);
  localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(7);

  logic [1:0]            sync_q;
  uart_state_e           state_q;
  logic [BAUD_CNT_W-1:0] cnt_q;
  logic [BIT_CNT_W-1:0]  bit_q;
  logic [7:0]            shift_q;
  logic [7:0]            byte_q;
  logic                  full_q;
  logic                  rx_s;

  assign rx_s      = sync_q[1];
  assign rx_full_o = full_q;
  assign byte_o    = byte_q;

  // Two-flop synchronizer for the asynchronous serial input, idling high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_i};
    end
  end

  // Receive FSM; a frame with a low stop bit leaves byte_q and full_q untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= 8'h00;
      byte_q  <= 8'h00;
      full_q  <= 1'b0;
    end else begin
      full_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rx_s) begin
            state_q <= START;
          end
        end
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            bit_q <= '0;
            state_q <= rx_s ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[7:1]};
            if (bit_q == LAST_BIT) begin
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (rx_s) begin
              byte_q <= shift_q;
              full_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serializer: one byte per accepted strobe, each bit held for a full baud period.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en_i,
  input  logic [7:0] byte_i,
  output logic       tx_empty_o,
  output logic       tx_o
);

  localparam logic [BAUD_CNT_W-1:0] BIT_LAST = BAUD_CNT_W'(clks_per_bit(CLK_FREQ, BAUD) - 1);
  localparam logic [BIT_CNT_W-1:0]  LAST_BIT = BIT_CNT_W'(7);

  uart_state_e           state_q;
  logic [BAUD_CNT_W-1:0] cnt_q;
  logic [BIT_CNT_W-1:0]  bit_q;
  logic [7:0]            shift_q;
  logic                  tx_q;
  logic                  empty_q;
  logic                  bit_done_s;

  assign bit_done_s = (cnt_q == BIT_LAST);
  assign tx_o       = tx_q;
  assign tx_empty_o = empty_q;

  // Transmit FSM; the line level and the idle flag are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
      empty_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (wr_en_i) begin
            shift_q <= byte_i;
            tx_q    <= 1'b0;
            empty_q <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (bit_done_s) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_done_s) begin
            cnt_q <= '0;
            if (bit_q == LAST_BIT) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_q   <= bit_q + 1'b1;
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[7:1]};
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (bit_done_s) begin
            cnt_q   <= '0;
            empty_q <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_q   <= '0;
          tx_q    <= 1'b1;
          empty_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart.sv
// Full-duplex 8N1 uart top: independent transmitter and receiver sharing only clock and reset.
module uart
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic   clk,
  input  logic   rst,
  uart_if.slave  bus,
  input  logic   rx_i,
  output logic   tx_o
);

  uart_tx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_tx (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (bus.wr_en),
    .byte_i     (bus.tx_byte),
    .tx_empty_o (bus.tx_empty),
    .tx_o       (tx_o)
  );

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx_i      (rx_i),
    .rx_full_o (bus.rx_full),
    .byte_o    (bus.rx_byte)
  );

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: loopback and directly driven frames against a frame-level model.
module tb_uart;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int HALF     = CPB / 2;
  localparam int FRAME    = 10 * CPB;
  localparam int RX_LAT   = 2 + (19 * CPB) / 2;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic loop   = 1'b1;
  logic rx_drv = 1'b1;
  logic tx_o;
  logic rx_i;

  int         total   = 0;
  int         bad     = 0;
  logic [7:0] rxq[$];
  logic [7:0] last_rx = 8'h00;

  uart_if bus();

  assign rx_i = loop ? tx_o : rx_drv;

  uart #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .rx_i (rx_i),
    .tx_o (tx_o)
  );

  always #5 clk = ~clk;

  // every cycle rx_full is seen high contributes one received byte
  always @(negedge clk) begin
    if (bus.rx_full === 1'b1) rxq.push_back(bus.rx_byte);
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_rx(input logic [7:0] b);
    logic [7:0] got;
    if (rxq.size() == 0) begin
      check("rx_missing", 0, 1);
    end else begin
      got = rxq.pop_front();
      check("rx_byte", int'(got), int'(b));
    end
    last_rx = b;
  endtask

  task automatic check_no_rx();
    check("rx_extra", rxq.size(), 0);
  endtask

  // called on a negedge; raises wr_en once the transmitter reports idle
  task automatic start_write(input logic [7:0] b);
    int n;
    n = 0;
    while (bus.tx_empty !== 1'b1 && n < 20 * CPB) begin
      @(negedge clk);
      n++;
    end
    check("tx_ready", int'(bus.tx_empty), 1);
    bus.wr_en   = 1'b1;
    bus.tx_byte = b;
  endtask

  // follows one transmitted frame, checking each bit centre and the busy length
  task automatic frame_watch(input logic [7:0] b, input int poke_at, input logic [7:0] poke_b);
    logic [9:0] frame;
    int j;
    int low;
    frame = {1'b1, b, 1'b0};
    @(negedge clk);
    bus.wr_en = 1'b0;
    check("tx_start", int'({bus.tx_empty, tx_o}), 0);
    j   = 0;
    low = 0;
    while (bus.tx_empty === 1'b0 && j < FRAME + 2 * CPB) begin
      if (j == poke_at) begin
        bus.wr_en   = 1'b1;
        bus.tx_byte = poke_b;
      end else begin
        bus.wr_en = 1'b0;
      end
      if ((j % CPB) == HALF && (j / CPB) < 10) check("tx_bit", int'(tx_o), int'(frame[j / CPB]));
      low++;
      @(negedge clk);
      j++;
    end
    bus.wr_en = 1'b0;
    check("tx_busy_len", low, FRAME);
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop, output int lat);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    lat   = -1;
    for (int j = 0; j < FRAME; j++) begin
      rx_drv = frame[j / CPB];
      @(negedge clk);
      if (bus.rx_full === 1'b1 && lat < 0) lat = j + 1;
    end
    rx_drv = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic check_reset_state();
    check("rst_tx", int'(tx_o), 1);
    check("rst_tx_empty", int'(bus.tx_empty), 1);
    check("rst_rx_full", int'(bus.rx_full), 0);
    check("rst_rx_byte", int'(bus.rx_byte), 0);
  endtask

  initial begin
    logic [7:0] b;
    logic       s;
    int         lat;
    int         n;
    int         g;

    bus.wr_en   = 1'b0;
    bus.tx_byte = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_state();
    rst = 1'b0;
    @(negedge clk);

    // loopback of 0xF2
    start_write(8'hF2);
    frame_watch(8'hF2, -1, 8'h00);
    expect_rx(8'hF2);
    check_no_rx();

    // a strobe mid-frame is dropped, not queued
    start_write(8'h55);
    frame_watch(8'h55, 4 * CPB + 3, 8'hAA);
    expect_rx(8'h55);
    n = 0;
    repeat (2 * FRAME) begin
      @(negedge clk);
      if (tx_o !== 1'b1 || bus.tx_empty !== 1'b1) n++;
    end
    check("idle_after_drop", n, 0);
    check_no_rx();

    // back-to-back: second strobe on the cycle tx_empty returns
    start_write(8'h00);
    frame_watch(8'h00, -1, 8'h00);
    bus.wr_en   = 1'b1;
    bus.tx_byte = 8'hFF;
    frame_watch(8'hFF, -1, 8'h00);
    expect_rx(8'h00);
    expect_rx(8'hFF);
    check_no_rx();

    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      start_write(b);
      frame_watch(b, -1, 8'h00);
      expect_rx(b);
      check_no_rx();
    end

    // directly driven receive line
    loop = 1'b0;
    drive_frame(8'hA5, 1'b0, lat);
    check_no_rx();
    check("rx_hold_ferr", int'(bus.rx_byte), int'(last_rx));
    drive_frame(8'h3C, 1'b1, lat);
    expect_rx(8'h3C);
    check("rx_byte_out", int'(bus.rx_byte), 32'h3C);
    check("rx_latency", int'(lat >= RX_LAT - 1 && lat <= RX_LAT + 2), 1);

    g = $urandom_range(1, CPB / 4);
    rx_drv = 1'b0;
    repeat (g) @(negedge clk);
    rx_drv = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check_no_rx();
    check("rx_hold_glitch", int'(bus.rx_byte), int'(last_rx));
    drive_frame(8'h81, 1'b1, lat);
    expect_rx(8'h81);

    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      s = 1'($urandom_range(0, 1));
      drive_frame(b, s, lat);
      if (s) expect_rx(b);
      check_no_rx();
      check("rx_hold_rand", int'(bus.rx_byte), int'(last_rx));
    end

    // reset during the data bits of a directly driven receive frame
    b = 8'h96;
    for (int j = 0; j < 4 * CPB; j++) begin
      rx_drv = (j < CPB) ? 1'b0 : b[(j / CPB) - 1];
      @(negedge clk);
    end
    rx_drv = 1'b1;
    rst    = 1'b1;
    @(negedge clk);
    check_reset_state();
    rst     = 1'b0;
    last_rx = 8'h00;
    repeat (FRAME) @(negedge clk);
    check_no_rx();

    // reset during the data bits of a loopback frame
    loop = 1'b1;
    drive_frame(8'h00, 1'b1, lat);
    loop = 1'b0;
    drive_frame(8'h5A, 1'b1, lat);
    expect_rx(8'h5A);
    loop = 1'b1;
    start_write(8'hC3);
    @(negedge clk);
    bus.wr_en = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state();
    rst     = 1'b0;
    last_rx = 8'h00;
    repeat (2 * CPB) @(negedge clk);
    check_no_rx();
    start_write(8'h7E);
    frame_watch(8'h7E, -1, 8'h00);
    expect_rx(8'h7E);
    check_no_rx();
    check("rx_byte_final", int'(bus.rx_byte), 32'h7E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
